ippcrc_crc32_chk: RTL and testbench
===================================

IPPCRC_CRC32_CHK -- requirements
Module: ippcrc_crc32_chk

Interface
REQ-001 Parameter LENW, default 16: width of the frame byte-length result and of each statistics counter.
REQ-002 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous, active-high.
REQ-004 di  input  32  Frame data word; first byte on di[7:0], last byte on di[31:24]; bit 0 of each byte is the first bit transmitted.
REQ-005 dvld  input  1  di, sop, eop and nob are valid this cycle.
REQ-006 sop  input  1  Word is the first word of a frame; qualified by dvld.
REQ-007 eop  input  1  Word is the last word of a frame; qualified by dvld.
REQ-008 nob  input  2  Valid bytes in an eop word: 0 means 4, 1 to 3 mean 1 to 3 bytes in the low lanes; ignored when eop=0.
REQ-009 cnt_clr  input  1  Synchronous clear of all statistics counters.
REQ-010 chk_vld  output  1  One-cycle pulse: a frame result is presented.
REQ-011 chk_ok  output  1  Frame FCS good and length at least 5 bytes; valid while chk_vld=1.
REQ-012 chk_len  output  LENW  Frame byte count including FCS, saturating; valid while chk_vld=1.
REQ-013 cnt_good, cnt_bad, cnt_abort  output  LENW each  Saturating counts of good, bad and aborted frames.

Function
REQ-014 CRC arithmetic is CRC-32 (poly 0x04C11DB7), MSB-first register form, with the same bit ordering as the team's ippcrc_crc32_32b step (32-bit data bit-reversed, then XORed into the register).
REQ-015 Full words use the 32-bit step; a partial eop word uses 8-bit steps applied to bytes in lane order 0 to nob-1; unused lanes have no effect on the result.
REQ-016 States: IDLE and INFRM.
REQ-017 In IDLE, dvld with sop loads the register as 0xFFFFFFFF stepped with the current word; the block moves to INFRM, or stays in IDLE if eop is also set.
REQ-018 In IDLE, dvld without sop is discarded with no state or counter change.
REQ-019 In INFRM, dvld without sop steps the register; dvld with eop returns the block to IDLE.
REQ-020 In INFRM, dvld with sop aborts the open frame: cnt_abort increments, no chk_vld is issued for it, and the word starts a new frame exactly as in REQ-017.
REQ-021 A frame is good when the register after the final byte, including the FCS, equals residue 0xC704DD7B and chk_len is at least 5; otherwise it is bad.
REQ-022 Latency: for an eop word accepted in cycle N, chk_vld, chk_ok and chk_len are registered and valid in cycle N+1 only.
REQ-023 The good or bad counter increments in cycle N+1.
REQ-024 chk_ok and chk_len hold their last values when chk_vld=0.
REQ-025 chk_len adds 4 per word, or nob (with 0 read as 4) on the eop word, and saturates at all-ones.
REQ-026 Counters saturate at all-ones.
REQ-027 cnt_clr has priority over any increment in the same cycle; the counters read 0 in the following cycle.
REQ-028 Back-to-back frames (eop in cycle N, sop in cycle N+1) run at full rate with no idle cycle required.
REQ-029 dvld=0 cycles inside a frame freeze all state.

Reset
REQ-030 With rst=1 at a clock edge: state goes to IDLE; the CRC register is set to 0xFFFFFFFF; chk_vld, chk_ok, chk_len and all counters are set to 0.
REQ-031 rst applied mid-frame discards that frame with no result pulse and no counter change.
REQ-032 rst has priority over every other input in the same cycle.

Verification
REQ-033 Good frame, 4 words:
- words 0x34333231 (sop), 0x38373635, 0xF4392639, then 0x000000CB with eop and nob=1;
- required: one cycle later chk_vld=1, chk_ok=1, chk_len=13, cnt_good=1.
REQ-034 Corrupted frame: same frame with the third word 0xF4392638 -> chk_ok=0, chk_len=13, cnt_bad=1.
REQ-035 Runt frame: a single word with sop=eop=1, nob=3 -> chk_vld=1, chk_ok=0, chk_len=3.
REQ-036 Abort: sop, one data word, then a new sop carrying the REQ-033 frame -> cnt_abort=1, then exactly one chk_vld with chk_ok=1, chk_len=13.
REQ-037 Stress: back-to-back REQ-033 frames with random dvld gaps plus one mid-frame rst -> one good result per complete frame, none for the frame cut by rst.
REQ-038 Counters: cnt_clr asserted in the same cycle as a good-frame increment -> cnt_good=0 the next cycle; with LENW=4, 16 good frames -> cnt_good holds at 15.

Source files
------------

// File: rtl/ippcrc_crc32_chk.sv
// Ethernet-style CRC-32 frame checker with byte length and saturating statistics.
// Latency: result (chk_vld/chk_ok/chk_len) registered one cycle after the eop word is accepted.
// Backpressure: none; the block always accepts a dvld word, and dvld=0 freezes all state.
module ippcrc_crc32_chk #(
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     di,
  input  logic            dvld,
  input  logic            sop,
  input  logic            eop,
  input  logic [1:0]      nob,
  input  logic            cnt_clr,
  output logic            chk_vld,
  output logic            chk_ok,
  output logic [LENW-1:0] chk_len,
  output logic [LENW-1:0] cnt_good,
  output logic [LENW-1:0] cnt_bad,
  output logic [LENW-1:0] cnt_abort
);

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] SEED    = 32'hFFFFFFFF;

  typedef enum logic {IDLE, INFRM} state_t;

  // One byte through the MSB-first register; bit 0 of the byte goes in first.
  function automatic logic [31:0] f_step8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r[31-i] = r[31-i] ^ b[i];
    for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  // Full word: data bit-reversed, XORed into the register, then 32 shifts.
  function automatic logic [31:0] f_step32(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) r[31-i] = r[31-i] ^ d[i];
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_crc;
  logic [LENW-1:0] r_len;
  logic            r_chk_vld;
  logic            r_chk_ok;
  logic [LENW-1:0] r_chk_len;
  logic [LENW-1:0] r_cnt_good;
  logic [LENW-1:0] r_cnt_bad;
  logic [LENW-1:0] r_cnt_abort;

  logic            w_acc;
  logic            w_abort;
  logic            w_done;
  logic            w_good;
  logic [31:0]     w_base;
  logic [31:0]     w_b1;
  logic [31:0]     w_b2;
  logic [31:0]     w_b3;
  logic [31:0]     w_crc_nxt;
  logic [2:0]      w_nbytes;
  logic [LENW-1:0] w_len_base;
  logic [LENW:0]   w_len_sum;
  logic [LENW-1:0] w_len_nxt;

  // Next CRC and running length for the word on the bus; a sop word restarts both.
  always_comb begin
    w_base     = sop ? SEED : r_crc;
    w_b1       = f_step8(w_base, di[7:0]);
    w_b2       = f_step8(w_b1, di[15:8]);
    w_b3       = f_step8(w_b2, di[23:16]);
    w_crc_nxt  = f_step32(w_base, di);
    w_nbytes   = 3'd4;
    if (eop && (nob != 2'd0)) begin
      w_nbytes = {1'b0, nob};
      case (nob)
        2'd1:    w_crc_nxt = w_b1;
        2'd2:    w_crc_nxt = w_b2;
        default: w_crc_nxt = w_b3;
      endcase
    end
    w_len_base = sop ? '0 : r_len;
    w_len_sum  = {1'b0, w_len_base} + {{(LENW-2){1'b0}}, w_nbytes};
    w_len_nxt  = w_len_sum[LENW] ? '1 : w_len_sum[LENW-1:0];
    w_good     = (w_crc_nxt == RESIDUE) && (w_len_nxt >= LENW'(5));
  end

  // Frame FSM: next state and per-cycle accept/abort/done strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    w_abort     = 1'b0;
    w_done      = 1'b0;
    if (dvld) begin
      if (sop) begin
        w_acc       = 1'b1;
        w_abort     = (r_state == INFRM);
        w_done      = eop;
        w_state_nxt = eop ? IDLE : INFRM;
      end else if (r_state == INFRM) begin
        w_acc       = 1'b1;
        w_done      = eop;
        w_state_nxt = eop ? IDLE : INFRM;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // CRC/length accumulators and the registered frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc     <= SEED;
      r_len     <= '0;
      r_chk_vld <= 1'b0;
      r_chk_ok  <= 1'b0;
      r_chk_len <= '0;
    end else begin
      r_chk_vld <= w_done;
      if (w_acc) begin
        r_crc <= w_crc_nxt;
        r_len <= w_len_nxt;
      end
      if (w_done) begin
        r_chk_ok  <= w_good;
        r_chk_len <= w_len_nxt;
      end
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt_good  <= '0;
      r_cnt_bad   <= '0;
      r_cnt_abort <= '0;
    end else begin
      if (w_done && w_good && (r_cnt_good != '1))   r_cnt_good  <= r_cnt_good + 1'b1;
      if (w_done && !w_good && (r_cnt_bad != '1))   r_cnt_bad   <= r_cnt_bad + 1'b1;
      if (w_abort && (r_cnt_abort != '1))           r_cnt_abort <= r_cnt_abort + 1'b1;
    end
  end

  assign chk_vld   = r_chk_vld;
  assign chk_ok    = r_chk_ok;
  assign chk_len   = r_chk_len;
  assign cnt_good  = r_cnt_good;
  assign cnt_bad   = r_cnt_bad;
  assign cnt_abort = r_cnt_abort;

endmodule

// File: tb/tb_ippcrc_crc32_chk.sv
// Directed bench for ippcrc_crc32_chk: a LENW=16 instance plus a LENW=4 instance on the same stimulus.
// Expected values are hand-derived from the "123456789" CRC-32 frame (FCS 0xCBF43926, 13 bytes).
// Inputs driven on the falling edge, outputs checked on the following falling edge.
module tb_ippcrc_crc32_chk;

  logic        clk;
  logic        rst;
  logic [31:0] di;
  logic        dvld;
  logic        sop;
  logic        eop;
  logic [1:0]  nob;
  logic        cnt_clr;

  logic        chk_vld,  chk_ok;
  logic [15:0] chk_len,  cnt_good,  cnt_bad,  cnt_abort;
  logic        chk_vld4, chk_ok4;
  logic [3:0]  chk_len4, cnt_good4, cnt_bad4, cnt_abort4;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_okp = 0;
  int snap_p;
  int snap_o;

  ippcrc_crc32_chk #(.LENW(16)) dut (
    .clk(clk), .rst(rst), .di(di), .dvld(dvld), .sop(sop), .eop(eop), .nob(nob),
    .cnt_clr(cnt_clr), .chk_vld(chk_vld), .chk_ok(chk_ok), .chk_len(chk_len),
    .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_abort(cnt_abort)
  );

  ippcrc_crc32_chk #(.LENW(4)) dut4 (
    .clk(clk), .rst(rst), .di(di), .dvld(dvld), .sop(sop), .eop(eop), .nob(nob),
    .cnt_clr(cnt_clr), .chk_vld(chk_vld4), .chk_ok(chk_ok4), .chk_len(chk_len4),
    .cnt_good(cnt_good4), .cnt_bad(cnt_bad4), .cnt_abort(cnt_abort4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result-pulse monitor for the LENW=16 instance.
  always @(negedge clk) begin
    if (chk_vld) begin
      n_pulse++;
      if (chk_ok) n_okp++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] d, input logic s, input logic e, input logic [1:0] n,
                     input logic clr, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin
      @(negedge clk);
      dvld = 1'b0; sop = 1'b0; eop = 1'b0; cnt_clr = 1'b0; di = $urandom;
    end
    @(negedge clk);
    di = d; sop = s; eop = e; nob = n; cnt_clr = clr; dvld = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    dvld = 1'b0; sop = 1'b0; eop = 1'b0; nob = 2'd0; cnt_clr = 1'b0; di = $urandom;
  endtask

  task automatic frame(input logic corrupt, input logic clr_eop, input int maxgap);
    put(32'h34333231, 1'b1, 1'b0, 2'd0, 1'b0, maxgap);
    put(32'h38373635, 1'b0, 1'b0, 2'd0, 1'b0, maxgap);
    put(corrupt ? 32'hF4392638 : 32'hF4392639, 1'b0, 1'b0, 2'd0, 1'b0, maxgap);
    put(32'h000000CB, 1'b0, 1'b1, 2'd1, clr_eop, maxgap);
  endtask

  initial begin
    rst = 1'b1; di = '0; dvld = 1'b0; sop = 1'b0; eop = 1'b0; nob = 2'd0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", 32'(chk_vld), 32'd0);
    chk("rst_ok", 32'(chk_ok), 32'd0);
    chk("rst_len", 32'(chk_len), 32'd0);
    chk("rst_good", 32'(cnt_good), 32'd0);
    chk("rst_bad", 32'(cnt_bad), 32'd0);
    chk("rst_abort", 32'(cnt_abort), 32'd0);

    // Word without sop while idle is dropped.
    put(32'h00001234, 1'b0, 1'b1, 2'd0, 1'b0, 0);
    idle();
    chk("nosop_vld", 32'(chk_vld), 32'd0);
    chk("nosop_bad", 32'(cnt_bad), 32'd0);

    // Good frame.
    frame(1'b0, 1'b0, 0);
    idle();
    chk("good_vld", 32'(chk_vld), 32'd1);
    chk("good_ok", 32'(chk_ok), 32'd1);
    chk("good_len", 32'(chk_len), 32'd13);
    chk("good_cnt", 32'(cnt_good), 32'd1);
    idle();
    chk("hold_vld", 32'(chk_vld), 32'd0);
    chk("hold_ok", 32'(chk_ok), 32'd1);
    chk("hold_len", 32'(chk_len), 32'd13);

    // Corrupted frame.
    frame(1'b1, 1'b0, 0);
    idle();
    chk("bad_vld", 32'(chk_vld), 32'd1);
    chk("bad_ok", 32'(chk_ok), 32'd0);
    chk("bad_len", 32'(chk_len), 32'd13);
    chk("bad_cnt", 32'(cnt_bad), 32'd1);

    // Runt: 3 bytes in one sop+eop word.
    put(32'h00333231, 1'b1, 1'b1, 2'd3, 1'b0, 0);
    idle();
    chk("runt_vld", 32'(chk_vld), 32'd1);
    chk("runt_ok", 32'(chk_ok), 32'd0);
    chk("runt_len", 32'(chk_len), 32'd3);
    chk("runt_bad", 32'(cnt_bad), 32'd2);

    // Abort: open frame interrupted by a new sop carrying the good frame.
    idle(); #2;
    snap_p = n_pulse;
    put(32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 1'b0, 0);
    put(32'h01020304, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'h34333231, 1'b1, 1'b0, 2'd0, 1'b0, 0);
    idle();
    chk("abort_cnt", 32'(cnt_abort), 32'd1);
    put(32'h38373635, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'hF4392639, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'h000000CB, 1'b0, 1'b1, 2'd1, 1'b0, 0);
    idle();
    chk("abort_vld", 32'(chk_vld), 32'd1);
    chk("abort_ok", 32'(chk_ok), 32'd1);
    chk("abort_len", 32'(chk_len), 32'd13);
    chk("abort_good", 32'(cnt_good), 32'd2);
    idle(); #2;
    chk("abort_pulses", 32'(n_pulse - snap_p), 32'd1);

    // Clear in the same cycle as a good-frame increment.
    frame(1'b0, 1'b1, 0);
    idle();
    chk("clr_vld", 32'(chk_vld), 32'd1);
    chk("clr_good", 32'(cnt_good), 32'd0);
    chk("clr_bad", 32'(cnt_bad), 32'd0);
    chk("clr_abort", 32'(cnt_abort), 32'd0);

    // Stress: cut frame plus reset (with a competing sop+eop word), then gapped back-to-back frames.
    idle(); #2;
    snap_p = n_pulse; snap_o = n_okp;
    put(32'h34333231, 1'b1, 1'b0, 2'd0, 1'b0, 0);
    put(32'h38373635, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'h00333231, 1'b1, 1'b1, 2'd3, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dvld = 1'b0; sop = 1'b0; eop = 1'b0;
    // Continuation words of the cut frame must be ignored after reset.
    put(32'hF4392639, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'h000000CB, 1'b0, 1'b1, 2'd1, 1'b0, 0);
    for (int f = 0; f < 5; f++) frame(1'b0, 1'b0, 2);
    idle(); idle(); #2;
    chk("stress_pulses", 32'(n_pulse - snap_p), 32'd5);
    chk("stress_okp", 32'(n_okp - snap_o), 32'd5);
    chk("stress_good", 32'(cnt_good), 32'd5);
    chk("stress_bad", 32'(cnt_bad), 32'd0);
    chk("stress_abort", 32'(cnt_abort), 32'd0);

    // Saturation: 16 good frames on top of 5.
    for (int f = 0; f < 16; f++) frame(1'b0, 1'b0, 0);
    idle();
    chk("sat_good4", 32'(cnt_good4), 32'd15);
    chk("sat_good16", 32'(cnt_good), 32'd21);

    // 20-byte frame: length saturates in the narrow instance.
    put(32'h11111111, 1'b1, 1'b0, 2'd0, 1'b0, 0);
    for (int w = 0; w < 3; w++) put(32'h22222222, 1'b0, 1'b0, 2'd0, 1'b0, 0);
    put(32'h33333333, 1'b0, 1'b1, 2'd0, 1'b0, 0);
    idle();
    chk("len20_16", 32'(chk_len), 32'd20);
    chk("len20_4", 32'(chk_len4), 32'd15);
    chk("len20_ok", 32'(chk_ok), 32'd0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
